sha256_w_seed_loader_2: RTL
===========================

Name: sha256_w_seed_loader_2

Overview:
- Upstream neighbour of the second-hash message-expansion pipeline in the double-SHA256 core.
- Collects the 8-word first-hash digest, which arrives one 32-bit word per handshake, and assembles it into two 128-bit windows.
- Issues a single write pulse that seeds the first 128-bit window register of the compact message expander.
- The padding constants (0x80000000, zero words, length word) are hardwired downstream and are not produced here.

Parameters:
- WORD_W, 32: width of one message word; fixed at 32 for SHA256.
- NUM_WORDS, 8: digest words collected per block; fixed at 8. The counter is sized $clog2(NUM_WORDS)+1.

Ports:
- CLK  input  1  system clock; all state on the rising edge.
- RST  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous abort; discards the partial or held block.
- word_valid  input  1  word_in carries a valid digest word.
- word_ready  output  1  loader can accept a word this cycle.
- word_in  input  32  digest word; H0 first, H7 last.
- out_valid  output  1  block_lo/block_hi hold a complete seed.
- out_ready  input  1  downstream window register can load.
- write_en  output  1  load strobe to the downstream window register; equals out_valid & out_ready.
- block_lo  output  128  {W0,W1,W2,W3}; W0 in [127:96], W3 in [31:0].
- block_hi  output  128  {W4,W5,W6,W7}; same ordering.
- word_count  output  4  number of words accepted for the current block (0..8).

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, word_count=0, out_valid=0.
  - block_lo=0 and block_hi=0.
  - word_ready=0 while RST is low.
  - The first accept is possible in the first edge after RST deasserts.
- States:
  - IDLE: word_ready=1, out_valid=0. An accepted word goes to slot 0 and the state moves to COLLECT with count=1.
  - COLLECT: word_ready=1, out_valid=0. Each accepted word (word_valid & word_ready) goes to slot word_count and count increments. The accept that makes count=8 moves the state to HOLD.
  - HOLD: word_ready=0, out_valid=1, and the block is stable. When out_ready=1, write_en=1 in that same cycle; the next state is IDLE and count returns to 0.
- Latency: out_valid rises on the clock edge that follows the 8th accept.
- Minimum block period: 9 cycles (8 accepts + 1 handoff). There is no back-to-back overlap; a word offered during HOLD is not taken.
- Data registers:
  - Only the addressed slot is written.
  - Slots are not cleared on handoff; stale words remain until overwritten.
  - block_lo and block_hi are driven directly from the slot registers.
- Stalls:
  - word_valid=0 in COLLECT holds count and data; there is no timeout.
  - out_ready=0 in HOLD holds out_valid=1 and the data indefinitely.
- flush=1 (synchronous, highest priority):
  - Next state IDLE, count=0, out_valid=0.
  - Any word presented in the same cycle is dropped.
  - write_en=0 in a flush cycle, even if out_ready=1 in HOLD.
- write_en is combinational from registered out_valid and the input out_ready. It is never asserted outside HOLD.
- word_count never exceeds 8. The counter cannot wrap because word_ready=0 in HOLD.
- Reset asserted mid-block returns all state to reset values immediately; the partial block is lost.

Optional Feature:
- Macro: SHA256_SEED_BYTE_SWAP_EN.
- Defined: each word_in is byte-reversed before storage, i.e. {w[7:0],w[15:8],w[23:16],w[31:24]}. This serves a little-endian digest source.
- Undefined: words are stored unmodified.
- Handshake timing and latency are identical in both builds.

Test Plan:
- Reset then 8 consecutive words 0x11111111..0x88888888 with word_valid=1 and out_ready=0. Required:
  - out_valid=1 on the edge after the 8th accept, word_count=8.
  - block_lo=0x11111111_22222222_33333333_44444444.
  - block_hi=0x55555555_66666666_77777777_88888888.
- Same load, then out_ready held 0 for 5 cycles, then 1. Required: data and out_valid stable throughout; write_en=1 for exactly one cycle; next cycle state=IDLE, word_count=0, word_ready=1.
- Words 0xA0000000..0xA0000007 with word_valid toggling 1,0,1,0,... Required: word_count advances only on valid cycles; block_lo[127:96]=0xA0000000; block_hi[31:0]=0xA0000007.
- Accept 5 words, then flush=1 together with word_valid=1, then load 8 fresh words 0xB0..0xB7. Required: the flush-cycle word is dropped; no write_en before the new block; block_lo[127:96]=0x000000B0.
- Drive RST low for 1 cycle after 3 accepted words. Required: outputs return to 0 immediately and word_ready=0 during reset. A following 8-word load completes normally.
- With SHA256_SEED_BYTE_SWAP_EN defined, word_in=0x01234567 as the first word. Required: block_lo[127:96]=0x67452301. Without the macro: 0x01234567.

Source files
------------

// File: rtl/sha256_w_seed_loader_2_if.sv
// Handshake bundle between the digest-word source, the seed loader and the
// second-hash window register.
interface sha256_w_seed_loader_2_if;
    logic         word_valid;
    logic         word_ready;
    logic [31:0]  word_in;
    logic         out_valid;
    logic         out_ready;
    logic         write_en;
    logic [127:0] block_lo;
    logic [127:0] block_hi;
    logic [3:0]   word_count;

    modport slave (
        input  word_valid, word_in, out_ready,
        output word_ready, out_valid, write_en, block_lo, block_hi, word_count
    );

    modport master (
        output word_valid, word_in, out_ready,
        input  word_ready, out_valid, write_en, block_lo, block_hi, word_count
    );
endinterface

// File: rtl/sha256_w_seed_loader_2.sv
// Collects the 8-word first-hash digest and seeds the second-hash window register.
// Optional macro SHA256_SEED_BYTE_SWAP_EN byte-reverses each word before storage.
module sha256_w_seed_loader_2 #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     flush,
    sha256_w_seed_loader_2_if.slave  bus
);
    localparam int CNT_W = $clog2(NUM_WORDS) + 1;
    localparam int IDX_W = $clog2(NUM_WORDS);

    typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [WORD_W-1:0]   slot_q [NUM_WORDS];
    logic [WORD_W-1:0]   slot_d [NUM_WORDS];
    logic [WORD_W-1:0]   word_stored;
    logic                word_ready;
    logic                out_valid;
    logic                accept;

`ifdef SHA256_SEED_BYTE_SWAP_EN
    assign word_stored = {bus.word_in[7:0], bus.word_in[15:8],
                          bus.word_in[23:16], bus.word_in[31:24]};
`else
    assign word_stored = bus.word_in;
`endif

    assign accept = bus.word_valid & word_ready & ~flush;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            count_q <= '0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            for (int i = 0; i < NUM_WORDS; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Flush outranks every transition, including a handoff in HOLD.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (flush) begin
            state_d = IDLE;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_d = COLLECT;
                        count_d = CNT_W'(1);
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        count_d = count_q + CNT_W'(1);
                        if (count_q == CNT_W'(NUM_WORDS - 1)) begin
                            state_d = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    // Slots are never cleared on handoff; only the addressed slot changes.
    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++) begin
            slot_d[i] = slot_q[i];
        end
        if (accept) begin
            slot_d[count_q[IDX_W-1:0]] = word_stored;
        end
    end

    always_comb begin
        word_ready   = RST & (state_q != HOLD);
        out_valid    = (state_q == HOLD);
        bus.write_en = out_valid & bus.out_ready & ~flush;
    end

    assign bus.word_ready = word_ready;
    assign bus.out_valid  = out_valid;
    assign bus.word_count = count_q;
    assign bus.block_lo   = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};
    assign bus.block_hi   = {slot_q[4], slot_q[5], slot_q[6], slot_q[7]};
endmodule
